// File: rtl/nubus_pkg.sv
// nubus_pkg: shared definitions for the NuBus card memory arbiter.
//   - owner encoding driven on arb_owner_o
//   - arbiter state type
//   - default read data returned when a memory access times out
//   - latched memory request record
package nubus_pkg;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_SLV  = 2'b01;
  localparam logic [1:0] OWN_LOC  = 2'b10;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_LOC  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  write;
  } mem_req_t;

endpackage

// File: rtl/nubus_mem_watchdog.sv
// nubus_mem_watchdog: load/count/expire counter.
//   i_clk      clock (rising edge)
//   i_reset    synchronous active-high reset
//   i_load     clear the count (start of a new access)
//   i_count    count one stalled cycle
//   o_expired  count has reached TIMEOUT
// The count saturates at TIMEOUT and never wraps.
module nubus_mem_watchdog #(
  parameter int TIMEOUT = 255
)(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset)                      r_cnt <= '0;
    else if (i_load)                  r_cnt <= '0;
    else if (i_count && r_cnt != LIMIT) r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/nubus_mem_arbiter.sv
// nubus_mem_arbiter: shares the card's local memory port between the NuBus
// slave path and the on-card CPU/DMA (local) port.
//   nub_clkn, reset                 clock, synchronous active-high reset
//   slv_valid/addr/wdata/write      slave request (write strobes 0 = read)
//   slv_ready/error/rdata           slave completion (error = timed out)
//   loc_*                           local port, same meaning as slave port
//   mem_valid_o/addr_o/wdata_o/write_o  latched request to memory
//   mem_ready, mem_rdata            memory completion
//   arb_owner_o                     00 none, 01 slave, 10 local
// Slave has priority, but after SLV_MAX_BURST back-to-back slave grants with
// local waiting, local wins one grant. A watchdog ends stalled accesses with
// an error completion returning ERR_RDATA.
module nubus_mem_arbiter
  import nubus_pkg::*;
#(
  parameter int          SLV_MAX_BURST = 4,
  parameter int          TIMEOUT       = 255,
  parameter logic [31:0] ERR_RDATA     = ERR_RDATA_DEF
)(
  input  logic        nub_clkn,
  input  logic        reset,
  input  logic        slv_valid,
  input  logic [31:0] slv_addr,
  input  logic [31:0] slv_wdata,
  input  logic [3:0]  slv_write,
  output logic        slv_ready,
  output logic        slv_error,
  output logic [31:0] slv_rdata,
  input  logic        loc_valid,
  input  logic [31:0] loc_addr,
  input  logic [31:0] loc_wdata,
  input  logic [3:0]  loc_write,
  output logic        loc_ready,
  output logic        loc_error,
  output logic [31:0] loc_rdata,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_write_o,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  arb_owner_o
);

  localparam int SW = $clog2(SLV_MAX_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(SLV_MAX_BURST);

  arb_state_t    r_state;
  logic          r_mem_valid;
  mem_req_t      r_req;
  logic [1:0]    r_owner;
  logic [SW-1:0] r_streak;

  mem_req_t    w_slv_req;
  mem_req_t    w_loc_req;
  logic        w_slv_win;
  logic        w_loc_win;
  logic        w_grant;
  logic        w_expired;
  logic        w_done;
  logic [31:0] w_rdata;

  assign w_slv_req = '{addr: slv_addr, wdata: slv_wdata, write: slv_write};
  assign w_loc_req = '{addr: loc_addr, wdata: loc_wdata, write: loc_write};

  // Slave wins unless local is waiting and the slave streak is exhausted.
  assign w_slv_win = (r_state == ST_IDLE) && slv_valid &&
                     !(loc_valid && r_streak == STREAK_MAX);
  assign w_loc_win = (r_state == ST_IDLE) && !w_slv_win && loc_valid;
  assign w_grant   = w_slv_win || w_loc_win;

  nubus_mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk    (nub_clkn),
    .i_reset  (reset),
    .i_load   (w_grant),
    .i_count  (r_mem_valid && !mem_ready),
    .o_expired(w_expired)
  );

  // A real completion beats a simultaneous timeout.
  assign w_done  = r_mem_valid && (mem_ready || w_expired);
  assign w_rdata = mem_ready ? mem_rdata : ERR_RDATA;

  assign slv_ready = w_done && (r_state == ST_SLV);
  assign slv_error = slv_ready && !mem_ready;
  assign slv_rdata = slv_ready ? w_rdata : '0;
  assign loc_ready = w_done && (r_state == ST_LOC);
  assign loc_error = loc_ready && !mem_ready;
  assign loc_rdata = loc_ready ? w_rdata : '0;

  always_ff @(posedge nub_clkn) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_req       <= '0;
      r_owner     <= OWN_NONE;
      r_streak    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_slv_win) begin
            r_state     <= ST_SLV;
            r_mem_valid <= 1'b1;
            r_req       <= w_slv_req;
            r_owner     <= OWN_SLV;
            // Streak only grows while local is actually being held off.
            if (!loc_valid)                r_streak <= '0;
            else if (r_streak != STREAK_MAX) r_streak <= r_streak + SW'(1);
          end else if (w_loc_win) begin
            r_state     <= ST_LOC;
            r_mem_valid <= 1'b1;
            r_req       <= w_loc_req;
            r_owner     <= OWN_LOC;
            r_streak    <= '0;
          end else begin
            r_streak <= '0;
          end
        end
        ST_SLV, ST_LOC: begin
          // Return to IDLE forces the dead cycle between grants.
          if (w_done) begin
            r_state     <= ST_IDLE;
            r_mem_valid <= 1'b0;
            r_owner     <= OWN_NONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mem_valid <= 1'b0;
          r_owner     <= OWN_NONE;
        end
      endcase
    end
  end

  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_req.addr;
  assign mem_wdata_o = r_req.wdata;
  assign mem_write_o = r_req.write;
  assign arb_owner_o = r_owner;

endmodule
